// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer.
// Provides the default geometry (word width, channel count, select width)
// and the drop-counter width and its saturation value.
package demux_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_N_OUT  = 2;
    localparam int unsigned DEF_SEL_W  = 1;

    localparam int unsigned DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    // Next value of a counter that sticks at DROP_CNT_MAX instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] cnt);
        logic [DROP_CNT_W-1:0] nxt;
        nxt = cnt;
        if (cnt != DROP_CNT_MAX) begin
            nxt = cnt + DROP_CNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - write load_data into the slot at the next edge
//   load_data   - word to store
//   drain       - consumer takes the held word this cycle
//   valid       - slot is FULL
//   data        - held word (keeps its last value after draining)
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // A load wins over a drain, so a simultaneous drain+load keeps the slot FULL.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// Each channel owns a one-entry slot so a stalled consumer only blocks
// words aimed at its own channel. Words whose select is out of range are
// accepted and dropped, producing a one-cycle pulse and a saturating count.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   in_valid     - input word present
//   in_ready     - combinational: the word would be accepted this cycle
//   in_data      - input word
//   in_sel       - destination channel index
//   out_valid[i] - channel i holds a word
//   out_ready[i] - consumer i takes its word this cycle
//   out_data     - channel i at bits [i*WIDTH +: WIDTH]
//   drop_pulse   - one cycle after an out-of-range word is dropped
//   drop_count   - saturating number of dropped words
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_OUT = DEF_N_OUT,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   drop_pulse,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    logic                  sel_in_range_c;
    logic                  sel_ready_c;
    logic                  accept_c;
    logic                  drop_c;
    logic [N_OUT-1:0]      load_c;

    logic                  drop_pulse_q;
    logic                  drop_pulse_d;
    logic [DROP_CNT_W-1:0] drop_count_q;
    logic [DROP_CNT_W-1:0] drop_count_d;

    // Select decode and ready of the addressed slot; a loop keeps the
    // index compare free of out-of-range part selects for any SEL_W.
    always_comb begin
        sel_in_range_c = 1'b0;
        sel_ready_c    = 1'b0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (32'(in_sel) == i) begin
                sel_in_range_c = 1'b1;
                sel_ready_c    = !out_valid[i] || out_ready[i];
            end
        end
    end

    // Ready never looks at in_valid; dropped selects are always taken.
    always_comb begin
        in_ready = 1'b1;
        if (sel_in_range_c) begin
            in_ready = sel_ready_c;
        end
    end

    always_comb begin
        accept_c = in_valid && in_ready;
        drop_c   = accept_c && !sel_in_range_c;
    end

    // One-hot load strobe: at most one slot is written per cycle.
    always_comb begin
        load_c = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (accept_c && (32'(in_sel) == i)) begin
                load_c[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_c[g]),
            .load_data (in_data),
            .drain     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g*WIDTH +: WIDTH])
        );
    end

    // Drop reporting: pulse follows the accept by one cycle, count saturates.
    always_comb begin
        drop_pulse_d = drop_c;
        drop_count_d = drop_count_q;
        if (drop_c) begin
            drop_count_d = sat_inc(drop_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: a 2-channel instance for routing and
// backpressure, a 3-channel instance (2-bit select) for drop behaviour.
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N_OUT=2, SEL_W=1
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic [0:0]  a_in_sel;
    logic [1:0]  a_out_valid;
    logic [1:0]  a_out_ready;
    logic [63:0] a_out_data;
    logic        a_drop_pulse;
    logic [7:0]  a_drop_count;

    // Instance B: N_OUT=3, SEL_W=2
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [95:0] b_out_data;
    logic        b_drop_pulse;
    logic [7:0]  b_drop_count;

    demux_stream_1ton #(.WIDTH(32), .N_OUT(2), .SEL_W(1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .in_sel     (a_in_sel),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .drop_pulse (a_drop_pulse),
        .drop_count (a_drop_count)
    );

    demux_stream_1ton #(.WIDTH(32), .N_OUT(3), .SEL_W(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .in_sel     (b_in_sel),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .drop_pulse (b_drop_pulse),
        .drop_count (b_drop_count)
    );

    typedef struct {
        logic        sel;
        logic [31:0] data;
        logic        exp_ready;
        logic [1:0]  exp_valid;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h1111_0000, 1'b1, 2'b01};
        tbl[1] = '{1'b1, 32'h2222_0001, 1'b1, 2'b10};
        tbl[2] = '{1'b0, 32'h3333_0002, 1'b1, 2'b01};
        tbl[3] = '{1'b1, 32'h4444_0003, 1'b1, 2'b10};
        tbl[4] = '{1'b0, 32'h5555_0004, 1'b1, 2'b01};
        tbl[5] = '{1'b1, 32'h6666_0005, 1'b1, 2'b10};
        tbl[6] = '{1'b0, 32'h7777_0006, 1'b1, 2'b01};
        tbl[7] = '{1'b1, 32'h8888_0007, 1'b1, 2'b10};

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '0;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '0;

        #12;
        chk("rst_a_valid", 96'(a_out_valid), 96'(0));
        chk("rst_a_data",  96'(a_out_data),  96'(0));
        chk("rst_b_count", 96'(b_drop_count), 96'(0));
        chk("rst_b_pulse", 96'(b_drop_pulse), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Basic route to channel 1
        a_out_ready = 2'b11;
        a_in_sel = 1'b1; a_in_data = 32'h1234_5678; a_in_valid = 1'b1;
        #1;
        chk("route_ready", 96'(a_in_ready), 96'(1));
        cyc();
        a_in_valid = 1'b0;
        chk("route_valid", 96'(a_out_valid), 96'(2'b10));
        chk("route_data",  96'(a_out_data[63:32]), 96'(32'h1234_5678));
        cyc();
        chk("route_drain", 96'(a_out_valid), 96'(2'b00));

        // Full-rate alternating pass-through, one word per cycle
        for (int i = 0; i < 8; i++) begin
            a_in_sel = tbl[i].sel; a_in_data = tbl[i].data; a_in_valid = 1'b1;
            #1;
            chk($sformatf("tput_ready_%0d", i), 96'(a_in_ready), 96'(tbl[i].exp_ready));
            cyc();
            chk($sformatf("tput_valid_%0d", i), 96'(a_out_valid), 96'(tbl[i].exp_valid));
            chk($sformatf("tput_data_%0d", i),
                96'(a_out_data[32*int'(tbl[i].sel) +: 32]), 96'(tbl[i].data));
        end
        a_in_valid = 1'b0;
        cyc();
        chk("tput_idle", 96'(a_out_valid), 96'(2'b00));

        // Backpressure isolation
        a_out_ready = 2'b00;
        a_in_sel = 1'b0; a_in_data = 32'h1; a_in_valid = 1'b1;
        #1;
        chk("bp_first_ready", 96'(a_in_ready), 96'(1));
        cyc();
        chk("bp_ch0_full", 96'(a_out_valid), 96'(2'b01));
        a_in_data = 32'h2;
        #1;
        chk("bp_stall_ready", 96'(a_in_ready), 96'(0));
        cyc();
        chk("bp_ch0_hold_v", 96'(a_out_valid), 96'(2'b01));
        chk("bp_ch0_hold_d", 96'(a_out_data[31:0]), 96'(32'h1));
        a_in_sel = 1'b1; a_in_data = 32'h3;
        #1;
        chk("bp_ch1_ready", 96'(a_in_ready), 96'(1));
        cyc();
        chk("bp_both_full", 96'(a_out_valid), 96'(2'b11));
        chk("bp_ch1_data",  96'(a_out_data[63:32]), 96'(32'h3));
        chk("bp_ch0_still", 96'(a_out_data[31:0]), 96'(32'h1));
        a_in_sel = 1'b0; a_in_data = 32'h2; a_out_ready = 2'b01;
        #1;
        chk("bp_replace_ready", 96'(a_in_ready), 96'(1));
        cyc();
        a_in_valid = 1'b0;
        chk("bp_replace_valid", 96'(a_out_valid), 96'(2'b11));
        chk("bp_replace_data",  96'(a_out_data[31:0]), 96'(32'h2));
        a_out_ready = 2'b11;
        cyc();
        chk("bp_all_drained", 96'(a_out_valid), 96'(2'b00));

        // Out-of-range drop on the 3-channel instance
        b_out_ready = 3'b111;
        b_in_sel = 2'd3; b_in_data = 32'hDEAD; b_in_valid = 1'b1;
        #1;
        chk("drop_ready", 96'(b_in_ready), 96'(1));
        cyc();
        b_in_valid = 1'b0;
        chk("drop_pulse_hi", 96'(b_drop_pulse), 96'(1));
        chk("drop_count_1",  96'(b_drop_count), 96'(1));
        chk("drop_no_slot",  96'(b_out_valid), 96'(3'b000));
        cyc();
        chk("drop_pulse_lo", 96'(b_drop_pulse), 96'(0));
        chk("drop_count_hold", 96'(b_drop_count), 96'(1));

        // Channel 2 of the 3-channel instance is in range
        b_in_sel = 2'd2; b_in_data = 32'hC0DE_0002; b_in_valid = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        chk("b_ch2_valid", 96'(b_out_valid), 96'(3'b100));
        chk("b_ch2_data",  96'(b_out_data[95:64]), 96'(32'hC0DE_0002));

        // Build up state, then reset between edges
        b_out_ready = 3'b000;
        cyc();
        b_in_sel = 2'd0; b_in_data = 32'hAAAA_5555; b_in_valid = 1'b1;
        cyc();
        b_in_sel = 2'd3;
        cyc();
        cyc();
        b_in_valid = 1'b0;
        chk("pre_rst_count", 96'(b_drop_count), 96'(3));
        chk("pre_rst_ch0",   96'(b_out_data[31:0]), 96'(32'hAAAA_5555));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 96'(b_out_valid), 96'(3'b000));
        chk("mid_rst_data",  96'(b_out_data), 96'(0));
        chk("mid_rst_count", 96'(b_drop_count), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Saturation: 260 consecutive drops
        b_in_sel = 2'd3; b_in_valid = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            cyc();
            chk($sformatf("sat_pulse_%0d", i), 96'(b_drop_pulse), 96'(1));
            chk($sformatf("sat_count_%0d", i), 96'(b_drop_count), 96'((i > 255) ? 255 : i));
        end
        b_in_valid = 1'b0;
        cyc();
        chk("sat_pulse_end", 96'(b_drop_pulse), 96'(0));
        chk("sat_count_end", 96'(b_drop_count), 96'(255));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
